fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the CPU controller/decoder. It owns the program counter, sequences reads from the synchronous instruction/data RAM, captures the returned word into the instruction register and presents it to the controller with a valid/ready handshake. While an instruction is held, it muxes the RAM address to the controller's data access so LDR/STR share the single RAM port.

## Interface
Parameters:
- ADDR_W, 8, RAM address and PC width
- INSTR_W, 16, instruction/data word width
- RESET_PC, 0, PC value after reset
- RAM_LAT, 1, RAM read latency in cycles (legal 1..4)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- mem_rdata  in  INSTR_W  RAM read data
- mem_addr  out  ADDR_W  RAM address
- mem_write  out  1  RAM write enable
- instr  out  INSTR_W  instruction register contents to decoder
- instr_valid  out  1  instr holds an unconsumed instruction
- instr_ready  in  1  controller finished executing instr
- data_req  in  1  controller data access this cycle
- data_addr  in  ADDR_W  data access address
- data_we  in  1  data access is a store
- load_pc  in  1  branch: redirect PC on handshake
- pc_in  in  ADDR_W  branch target
- halt  in  1  current instruction is HALT
- pc  out  ADDR_W  address of next fetch

## Operation
- States: FETCH, LOADIR, ISSUE, HALTED.
- FETCH: mem_addr = pc; wait counter runs RAM_LAT cycles, then -> LOADIR.
- LOADIR: mem_addr still pc; at the clock edge ending this cycle, instr <= mem_rdata, pc <= pc + 1 (mod 2^ADDR_W, 255 -> 0 for ADDR_W=8), -> ISSUE.
- ISSUE: instr_valid = 1. mem_addr = data_req ? data_addr : pc. mem_write = data_req & data_we. Handshake = instr_valid & instr_ready.
- On handshake: halt=1 -> HALTED (halt wins over load_pc); else load_pc=1 -> pc <= pc_in, -> FETCH; else -> FETCH.
- HALTED: absorbing until reset; instr_valid=0, mem_write=0, mem_addr=pc, instr held.
- Outside ISSUE: data_req, data_we, load_pc, halt ignored; mem_write forced 0.
- instr is held stable for the whole of ISSUE.

## Timing
- Reset (async, immediate on reset=0): state=FETCH, pc=RESET_PC, instr=0, wait counter=0; outputs instr_valid=0, mem_write=0, mem_addr=RESET_PC.
- Reset asserted mid-fetch or mid-ISSUE aborts immediately; any in-flight store is dropped (mem_write falls combinationally).
- First instr_valid rises RAM_LAT+1 cycles after the first edge with reset=1 (2 cycles for RAM_LAT=1).
- Per-instruction fetch overhead: handshake edge -> instr_valid again after RAM_LAT+1 more cycles.
- A store issued in the same cycle as the handshake is performed (mem_write high in that cycle).
- Back-to-back: instr_ready held high makes instr_valid a 1-cycle pulse every RAM_LAT+2 cycles.
- mem_addr and mem_write are combinational from state and registered pc plus data_* inputs; no other comb paths.

## Structure
- Shared package cpu_pkg: state encoding (FETCH=2'd0, LOADIR=2'd1, ISSUE=2'd2, HALTED=2'd3), default widths, RESET_PC constant.
- One natural sub-module: fetch_pc_reg (PC register with async active-low reset, increment, parallel load; load priority over increment).
- Wait counter, FSM and address/write mux remain in fetch_unit.

## Test plan
- Reset release, RAM[0]=16'hD105, RAM_LAT=1 -> instr_valid high on 2nd cycle, instr=16'hD105, pc=1.
- instr_ready held high, RAM[0..2] preloaded -> three valid pulses each 3 cycles apart, instr 0,1,2 in order, pc=3.
- ISSUE with data_req=1, data_addr=8'h40, data_we=1, instr_ready=1 same cycle -> mem_addr=8'h40, mem_write=1 for exactly that cycle, then FETCH from pc.
- Handshake with load_pc=1, pc_in=8'hFE -> next fetch at 8'hFE, then 8'hFF, then wrap to 8'h00.
- Handshake with halt=1 and load_pc=1 -> HALTED, instr_valid stays 0 for 20 cycles, pc unchanged, no mem_write.
- reset pulsed low during FETCH with RAM_LAT=3 -> instr_valid=0, pc=RESET_PC immediately; normal fetch of RAM[0] after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and default widths.
package cpu_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_INSTR_W  = 16;
    localparam int DEF_RESET_PC = 0;

    // Wide enough for RAM_LAT-1 with RAM_LAT up to 4.
    localparam int WAIT_CNT_W   = 3;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        LOADIR = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: async active-low reset, parallel load, +1 increment.
// A load takes priority over an increment in the same cycle.
module fetch_pc_reg
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_inc,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    output logic [ADDR_W-1:0] o_pc
);

    localparam logic [ADDR_W-1:0] RST_VAL = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] r_pc;

    // PC update: reset value, branch target, or wrap-around increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RST_VAL;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, sequences RAM reads into the
// instruction register and hands instructions to the controller.
//
// Handshake: instr_valid is high exactly while in ISSUE; an instruction is
// consumed on a rising clk edge where instr_valid & instr_ready are both 1.
// instr stays stable for the whole of ISSUE. While in ISSUE the RAM port is
// lent to the controller's data access (data_req/data_addr/data_we); in every
// other state those inputs, load_pc and halt are ignored and mem_write is 0.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int RESET_PC = DEF_RESET_PC,
    parameter int RAM_LAT  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_write,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               data_req,
    input  logic [ADDR_W-1:0]  data_addr,
    input  logic               data_we,
    input  logic               load_pc,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               halt,
    output logic [ADDR_W-1:0]  pc,
    output fetch_state_t       dbg_state
);

    // FETCH lasts RAM_LAT cycles; the counter wraps at this value.
    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(RAM_LAT - 1);

    fetch_state_t           r_state;
    fetch_state_t           w_state_nxt;
    logic [WAIT_CNT_W-1:0]  r_wait_cnt;
    logic [INSTR_W-1:0]     r_instr;
    logic [ADDR_W-1:0]      w_pc;
    logic                   w_handshake;
    logic                   w_pc_inc;
    logic                   w_pc_load;
    logic                   w_wait_done;

    assign w_wait_done = (r_wait_cnt == LAST_WAIT);
    assign w_handshake = instr_valid & instr_ready;
    // halt wins over load_pc on the consuming handshake.
    assign w_pc_load   = w_handshake & ~halt & load_pc;
    assign w_pc_inc    = (r_state == LOADIR);

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (reset),
        .i_inc      (w_pc_inc),
        .i_load     (w_pc_load),
        .i_load_val (pc_in),
        .o_pc       (w_pc)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH:   if (w_wait_done) w_state_nxt = LOADIR;
            LOADIR:  w_state_nxt = ISSUE;
            ISSUE:   if (w_handshake) w_state_nxt = halt ? HALTED : FETCH;
            HALTED:  w_state_nxt = HALTED;
            default: w_state_nxt = FETCH;
        endcase
    end

    // Outputs: valid flag and the shared RAM address/write mux.
    always_comb begin
        instr_valid = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = w_pc;
        if (r_state == ISSUE) begin
            instr_valid = 1'b1;
            mem_write   = data_req & data_we;
            if (data_req) begin
                mem_addr = data_addr;
            end
        end
    end

    // RAM wait counter: counts FETCH cycles, idles at zero elsewhere.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if ((r_state == FETCH) && !w_wait_done) begin
            r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Instruction register: captures RAM data at the end of LOADIR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr <= '0;
        end else if (r_state == LOADIR) begin
            r_instr <= mem_rdata;
        end
    end

    assign instr     = r_instr;
    assign pc        = w_pc;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance with RAM_LAT=1 for the main
// sequence, one with RAM_LAT=3 for the mid-fetch reset case.
module tb_fetch_unit;
  import cpu_pkg::*;

  // ---------------- clock ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT0 (RAM_LAT=1) ----------------
  logic         rst0_n;
  logic [15:0]  rdata0;
  logic [7:0]   addr0;
  logic         we0;
  logic [15:0]  instr0;
  logic         valid0;
  logic         ready0, dreq0, dwe0, ldpc0, halt0;
  logic [7:0]   daddr0, pcin0, pc0;
  fetch_state_t st0;

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(0), .RAM_LAT(1)) dut0 (
    .clk(clk), .reset(rst0_n), .mem_rdata(rdata0), .mem_addr(addr0),
    .mem_write(we0), .instr(instr0), .instr_valid(valid0),
    .instr_ready(ready0), .data_req(dreq0), .data_addr(daddr0),
    .data_we(dwe0), .load_pc(ldpc0), .pc_in(pcin0), .halt(halt0),
    .pc(pc0), .dbg_state(st0)
  );

  // ---------------- DUT1 (RAM_LAT=3) ----------------
  logic         rst1_n;
  logic [15:0]  rdata1;
  logic [7:0]   addr1;
  logic         we1;
  logic [15:0]  instr1;
  logic         valid1;
  logic         ready1;
  logic [7:0]   pc1;
  fetch_state_t st1;

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(0), .RAM_LAT(3)) dut1 (
    .clk(clk), .reset(rst1_n), .mem_rdata(rdata1), .mem_addr(addr1),
    .mem_write(we1), .instr(instr1), .instr_valid(valid1),
    .instr_ready(ready1), .data_req(1'b0), .data_addr(8'h00),
    .data_we(1'b0), .load_pc(1'b0), .pc_in(8'h00), .halt(1'b0),
    .pc(pc1), .dbg_state(st1)
  );

  // ---------------- RAM models ----------------
  logic [15:0] ram0 [256];
  logic [15:0] ram1 [256];
  logic [15:0] pipe1_a, pipe1_b;

  always @(posedge clk) rdata0 <= ram0[addr0];

  always @(posedge clk) begin
    pipe1_a <= ram1[addr1];
    pipe1_b <= pipe1_a;
    rdata1  <= pipe1_b;
  end

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid0(output int n);
    n = 0;
    while (valid0 !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic wait_valid1(output int n);
    n = 0;
    while (valid1 !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [15:0] exp_instr [4];
  int n;

  initial begin
    exp_instr[0] = 16'hD105;
    exp_instr[1] = 16'hA001;
    exp_instr[2] = 16'hB002;
    exp_instr[3] = 16'hC003;
    for (int i = 0; i < 256; i++) begin
      ram0[i] = 16'h0000;
      ram1[i] = 16'h0000;
    end
    for (int i = 0; i < 4; i++) ram0[i] = exp_instr[i];
    ram0[8'hFE] = 16'hFEFE;
    ram0[8'hFF] = 16'hFFFF;
    ram1[0]     = 16'hE0E0;
    ram1[1]     = 16'h1357;

    rst0_n = 1'b0; rst1_n = 1'b0;
    ready0 = 1'b0; dreq0 = 1'b0; dwe0 = 1'b0; ldpc0 = 1'b0; halt0 = 1'b0;
    daddr0 = 8'h00; pcin0 = 8'h00; ready1 = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", valid0, 0);
    chk("rst_mem_write", we0, 0);
    chk("rst_mem_addr", addr0, 8'h00);
    chk("rst_pc", pc0, 8'h00);
    chk("rst_instr", instr0, 16'h0000);
    chk("rst_state", st0, FETCH);

    // First fetch after release: valid after the 2nd edge
    rst0_n = 1'b1;
    wait_valid0(n);
    chk("first_latency", n, 2);
    chk("first_instr", instr0, 16'hD105);
    chk("first_pc", pc0, 8'h01);

    // Held while instr_ready low
    step();
    chk("hold_valid", valid0, 1);
    chk("hold_instr", instr0, 16'hD105);
    chk("hold_mem_addr", addr0, 8'h01);

    // Back-to-back with instr_ready held high
    ready0 = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      step();
      chk("b2b_pulse_low", valid0, 0);
      wait_valid0(n);
      chk("b2b_gap", n, 2);
      chk("b2b_instr", instr0, exp_instr[k]);
      chk("b2b_pc", pc0, k + 1);
    end

    // Store in the same cycle as the handshake
    dreq0 = 1'b1; daddr0 = 8'h40; dwe0 = 1'b1;
    #1;
    chk("store_addr", addr0, 8'h40);
    chk("store_we", we0, 1);
    step();
    chk("store_after_we", we0, 0);
    chk("store_after_addr", addr0, 8'h03);
    chk("store_after_valid", valid0, 0);
    dreq0 = 1'b0; dwe0 = 1'b0;
    wait_valid0(n);
    chk("fetch3_gap", n, 2);
    chk("fetch3_instr", instr0, 16'hC003);
    chk("fetch3_pc", pc0, 8'h04);

    // Branch to 0xFE, then run through the wrap
    ldpc0 = 1'b1; pcin0 = 8'hFE;
    step();
    ldpc0 = 1'b0;
    chk("br_pc", pc0, 8'hFE);
    chk("br_fetch_addr", addr0, 8'hFE);
    wait_valid0(n);
    chk("br_gap", n, 2);
    chk("br_instr_fe", instr0, 16'hFEFE);
    chk("br_pc_ff", pc0, 8'hFF);
    step();
    chk("fetch_addr_ff", addr0, 8'hFF);
    wait_valid0(n);
    chk("instr_ff", instr0, 16'hFFFF);
    chk("wrap_pc", pc0, 8'h00);
    step();
    chk("fetch_addr_wrap", addr0, 8'h00);
    wait_valid0(n);
    chk("wrap_instr", instr0, 16'hD105);
    chk("wrap_pc_next", pc0, 8'h01);

    // Halt wins over load_pc; HALTED absorbs everything
    halt0 = 1'b1; ldpc0 = 1'b1; pcin0 = 8'h55;
    dreq0 = 1'b1; daddr0 = 8'h40; dwe0 = 1'b1;
    step();
    for (int c = 0; c < 20; c++) begin
      chk("halt_valid", valid0, 0);
      chk("halt_we", we0, 0);
      chk("halt_pc", pc0, 8'h01);
      step();
    end
    chk("halt_state", st0, HALTED);
    chk("halt_addr", addr0, 8'h01);
    chk("halt_instr", instr0, 16'hD105);
    halt0 = 1'b0; ldpc0 = 1'b0; dreq0 = 1'b0; dwe0 = 1'b0; ready0 = 1'b0;

    // RAM_LAT=3: normal fetch, then reset mid-FETCH
    rst1_n = 1'b1;
    wait_valid1(n);
    chk("lat3_latency", n, 4);
    chk("lat3_instr", instr1, 16'hE0E0);
    chk("lat3_pc", pc1, 8'h01);
    ready1 = 1'b1;
    step();
    ready1 = 1'b0;
    step();
    chk("lat3_midfetch_state", st1, FETCH);
    chk("lat3_midfetch_pc", pc1, 8'h01);
    #2;
    rst1_n = 1'b0;
    #1;
    chk("lat3_rst_valid", valid1, 0);
    chk("lat3_rst_pc", pc1, 8'h00);
    chk("lat3_rst_addr", addr1, 8'h00);
    chk("lat3_rst_instr", instr1, 16'h0000);
    chk("lat3_rst_state", st1, FETCH);
    @(negedge clk);
    rst1_n = 1'b1;
    wait_valid1(n);
    chk("lat3_refetch_latency", n, 4);
    chk("lat3_refetch_instr", instr1, 16'hE0E0);
    chk("lat3_refetch_pc", pc1, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
